sprite_layer: RTL

- Parametrised sprite renderer for the VGA pipeline, and the successor to the combinational flat-bit-vector sprite buffer.
- Holds one sprite in an internal writable pixel RAM of SPR_W x SPR_H entries, each 3*CW bits of RGB.
- Compares the beam position (X_VGA, Y_VGA) against a sprite box that is latched once per frame, and scales the sprite by an integer factor using counters, not dividers.
- Emits registered RGB plus an opaque/valid flag, with fixed 2-cycle latency, to the downstream layer mixer.

---
 rtl/sprite_layer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sprite_layer.sv
// Single-sprite renderer: box test and scale counters, then RAM read, then registered RGB/valid.
// Optional horizontal mirroring is enabled with `define SPRITE_MIRROR_EN (adds FLIP_H input).
module sprite_layer #(
  parameter int unsigned       SPR_W      = 40,
  parameter int unsigned       SPR_H      = 40,
  parameter int unsigned       CW         = 4,
  parameter logic [3*CW-1:0]   TRANSP_KEY = '0,
  parameter int unsigned       AW         = $clog2(SPR_W * SPR_H)
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [9:0]      X_VGA,
  input  logic [9:0]      Y_VGA,
  input  logic            FRAME_START,
  input  logic [9:0]      X_OBJ,
  input  logic [9:0]      Y_OBJ,
  input  logic [2:0]      SCALE,
`ifdef SPRITE_MIRROR_EN
  input  logic            FLIP_H,
`endif
  input  logic            WR_EN,
  input  logic [AW-1:0]   WR_ADDR,
  input  logic [3*CW-1:0] WR_DATA,
  output logic [CW-1:0]   R_OUT,
  output logic [CW-1:0]   G_OUT,
  output logic [CW-1:0]   B_OUT,
  output logic            PIX_VALID
);

  localparam int unsigned NPIX = SPR_W * SPR_H;
  localparam int unsigned COLW = $clog2(SPR_W + 1);
  localparam int unsigned ROWW = $clog2(SPR_H + 1);

  logic [9:0]      x0_q, y0_q;
  logic [2:0]      sc_q;
  logic [COLW-1:0] col_q, col_e, col_a;
  logic [2:0]      hsub_q, hsub_e;
  logic [ROWW-1:0] row_q, row_n, row_e;
  logic [2:0]      vsub_q, vsub_n;
  logic [12:0]     x_end, y_end;
  logic            in_x, in_y, hit0, line_start, hit1_q, pix_d;
  logic [AW-1:0]   addr;
  logic [3*CW-1:0] mem [NPIX];
  logic [3*CW-1:0] rd_q;

  // 13-bit bounds so a box running past column/row 1023 clips instead of wrapping
  always_comb begin
    x_end      = {3'b000, x0_q} + 13'(SPR_W) * {10'd0, sc_q};
    y_end      = {3'b000, y0_q} + 13'(SPR_H) * {10'd0, sc_q};
    in_x       = (X_VGA >= x0_q) && ({3'b000, X_VGA} < x_end);
    in_y       = (Y_VGA >= y0_q) && ({3'b000, Y_VGA} < y_end);
    hit0       = in_x && in_y;
    line_start = (X_VGA == x0_q) && in_y;
  end

  always_comb begin
    col_e  = (X_VGA == x0_q) ? '0 : col_q;
    hsub_e = (X_VGA == x0_q) ? '0 : hsub_q;
    row_n  = row_q;
    vsub_n = vsub_q;
    if (Y_VGA == y0_q) begin
      row_n  = '0;
      vsub_n = '0;
    end else if (vsub_q == sc_q - 3'd1) begin
      row_n  = row_q + ROWW'(1);
      vsub_n = '0;
    end else begin
      vsub_n = vsub_q + 3'd1;
    end
    row_e = line_start ? row_n : row_q;
  end

`ifdef SPRITE_MIRROR_EN
  logic flip_q;
  assign col_a = flip_q ? (COLW'(SPR_W - 1) - col_e) : col_e;
`else
  assign col_a = col_e;
`endif

  assign addr  = AW'(32'(row_e) * SPR_W + 32'(col_a));
  assign pix_d = hit1_q && (rd_q != TRANSP_KEY);

  // Pixel RAM: not reset; a same-address read returns the pre-write word
  always_ff @(posedge CLK) begin
    if (WR_EN && (32'(WR_ADDR) < NPIX)) mem[WR_ADDR] <= WR_DATA;
    if (hit0) rd_q <= mem[addr];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      x0_q      <= '0;
      y0_q      <= '0;
      sc_q      <= 3'd1;
`ifdef SPRITE_MIRROR_EN
      flip_q    <= 1'b0;
`endif
      col_q     <= '0;
      hsub_q    <= '0;
      row_q     <= '0;
      vsub_q    <= '0;
      hit1_q    <= 1'b0;
      PIX_VALID <= 1'b0;
      R_OUT     <= '0;
      G_OUT     <= '0;
      B_OUT     <= '0;
    end else begin
      if (FRAME_START) begin
        x0_q   <= X_OBJ;
        y0_q   <= Y_OBJ;
        sc_q   <= (SCALE == 3'd0) ? 3'd1 : SCALE;
`ifdef SPRITE_MIRROR_EN
        flip_q <= FLIP_H;
`endif
      end
      if (in_x) begin
        if (hsub_e == sc_q - 3'd1) begin
          hsub_q <= '0;
          col_q  <= col_e + COLW'(1);
        end else begin
          hsub_q <= hsub_e + 3'd1;
          col_q  <= col_e;
        end
      end
      if (line_start) begin
        row_q  <= row_n;
        vsub_q <= vsub_n;
      end
      hit1_q    <= hit0;
      PIX_VALID <= pix_d;
      {R_OUT, G_OUT, B_OUT} <= pix_d ? rd_q : '0;
    end
  end

endmodule
